bpu_update_gen: RTL and testbench

//  Branch-resolution side of the bpu_update_t interface: consumes resolved branches from the

---
 rtl/bpu_update_gen_if.sv | 62 ++++++
 rtl/bpu_update_gen.sv | 128 ++++++++++++
 tb/tb_bpu_update_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bpu_update_gen_if.sv
// bpu_update_gen_if
//   Bundle between the dual-issue execute stage and the branch-resolution block.
//   The execute stage (master) drives the resolved slots, the stall and the
//   exception redirect request. The resolution block (slave) returns the
//   registered flush/br_target update, the current fetch epoch, the slot1 kill
//   and the perf counters.
//
//   Handshake semantics: there is no ready path. A slot is a one-cycle
//   offer; it is consumed only when sN_valid_i=1, stall_i=0 and its epoch tag
//   matches epoch_o in the same cycle, otherwise it is dropped. excp_valid_i is
//   always consumed on the cycle it is high. flush_o is a one-cycle pulse
//   that qualifies br_target_o.
//
//   Signals:
//     stall_i        execute stalled, slot resolutions not accepted
//     s0_* / s1_*    slot0 (older) / slot1 (younger) resolved control flow
//     excp_valid_i   exception/ertn redirect request, excp_target_i its target
//     flush_o        redirect pulse, br_target_o redirect word address
//     epoch_o        current fetch epoch
//     kill_s1_o      slot1 squashed because slot0 mispredicted this cycle
//     br_cnt_o       accepted resolutions, mis_cnt_o mispredict redirects
interface bpu_update_gen_if #(
  parameter int CNT_W = 32
);
  logic             stall_i;
  logic             s0_valid_i;
  logic             s0_epoch_i;
  logic [29:0]      s0_pc_i;
  logic [29:0]      s0_pred_npc_i;
  logic             s0_taken_i;
  logic [29:0]      s0_target_i;
  logic             s1_valid_i;
  logic             s1_epoch_i;
  logic [29:0]      s1_pc_i;
  logic [29:0]      s1_pred_npc_i;
  logic             s1_taken_i;
  logic [29:0]      s1_target_i;
  logic             excp_valid_i;
  logic [29:0]      excp_target_i;
  logic             flush_o;
  logic [29:0]      br_target_o;
  logic             epoch_o;
  logic             kill_s1_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] mis_cnt_o;

  modport master (
    output stall_i,
    output s0_valid_i, s0_epoch_i, s0_pc_i, s0_pred_npc_i, s0_taken_i, s0_target_i,
    output s1_valid_i, s1_epoch_i, s1_pc_i, s1_pred_npc_i, s1_taken_i, s1_target_i,
    output excp_valid_i, excp_target_i,
    input  flush_o, br_target_o, epoch_o, kill_s1_o, br_cnt_o, mis_cnt_o
  );

  modport slave (
    input  stall_i,
    input  s0_valid_i, s0_epoch_i, s0_pc_i, s0_pred_npc_i, s0_taken_i, s0_target_i,
    input  s1_valid_i, s1_epoch_i, s1_pc_i, s1_pred_npc_i, s1_taken_i, s1_target_i,
    input  excp_valid_i, excp_target_i,
    output flush_o, br_target_o, epoch_o, kill_s1_o, br_cnt_o, mis_cnt_o
  );
endinterface

// File: rtl/bpu_update_gen.sv
// bpu_update_gen
//   Branch-resolution side of the BPU update path. Compares the actual next PC
//   of each resolved slot with the predicted npc carried from fetch, picks the
//   highest-priority redirect (exception > slot0 mispredict > slot1 mispredict)
//   and drives a registered flush pulse plus br_target to the front end. A
//   1-bit fetch epoch toggles on every redirect so resolutions from the wrong
//   path are discarded. Perf counters track accepted resolutions and
//   mispredict redirects.
//
//   Ports:
//     clk        clock
//     rst_n      asynchronous active-low reset
//     bus        bpu_update_gen_if.slave (slot inputs, redirect outputs, counters)
//     dbg_state  FSM state, 0 = IDLE, 1 = REDIR
module bpu_update_gen #(
  parameter logic [29:0] RESET_TARGET = 30'h0700_0000,
  parameter int          CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  bpu_update_gen_if.slave    bus,
  output logic               dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t           state;
  logic             flush_q;
  logic [29:0]      target_q;
  logic             epoch_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  // Slot evaluation ---------------------------------------------------------
  logic        s0_acc, s1_acc;
  logic [29:0] s0_npc, s1_npc;
  logic        s0_mis, s1_mis;
  logic        redirect;
  logic        mis_redirect;
  logic [29:0] redirect_target;
  logic [1:0]  acc_count;

  // Not-taken next PC is pc+1 in word addresses; the 30-bit add wraps
  // 3FFF_FFFF -> 0 naturally.
  assign s0_npc = bus.s0_taken_i ? bus.s0_target_i : bus.s0_pc_i + 30'd1;
  assign s1_npc = bus.s1_taken_i ? bus.s1_target_i : bus.s1_pc_i + 30'd1;

  // epoch_q already holds the new epoch while in REDIR, so old-path
  // resolutions arriving during the flush cycle fail this match.
  assign s0_acc = bus.s0_valid_i & ~bus.stall_i & (bus.s0_epoch_i == epoch_q);
  assign s0_mis = s0_acc & (s0_npc != bus.s0_pred_npc_i);

  // Slot1 is younger; a slot0 mispredict means slot1 is on the wrong path.
  assign s1_acc = bus.s1_valid_i & ~bus.stall_i & (bus.s1_epoch_i == epoch_q) & ~s0_mis;
  assign s1_mis = s1_acc & (s1_npc != bus.s1_pred_npc_i);

  assign redirect     = bus.excp_valid_i | s0_mis | s1_mis;
  // Only a redirect actually caused by a mispredict is counted.
  assign mis_redirect = ~bus.excp_valid_i & (s0_mis | s1_mis);
  assign acc_count    = {1'b0, s0_acc} + {1'b0, s1_acc};

  always_comb begin
    redirect_target = s1_npc;
    if (bus.excp_valid_i) begin
      redirect_target = bus.excp_target_i;
    end else if (s0_mis) begin
      redirect_target = s0_npc;
    end
  end

  // Single FSM block, all outputs registered -------------------------------
  // IDLE -> REDIR on any redirect (flush pulses in REDIR). REDIR returns to
  // IDLE unless another redirect is decided, in which case it flushes again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_q   <= 1'b0;
      target_q  <= RESET_TARGET;
      epoch_q   <= 1'b0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_q + {{(CNT_W-2){1'b0}}, acc_count};
      if (mis_redirect) begin
        mis_cnt_q <= mis_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state)
        IDLE: begin
          if (redirect) begin
            state    <= REDIR;
            flush_q  <= 1'b1;
            target_q <= redirect_target;
            epoch_q  <= ~epoch_q;
          end else begin
            flush_q  <= 1'b0;
          end
        end
        REDIR: begin
          if (redirect) begin
            state    <= REDIR;
            flush_q  <= 1'b1;
            target_q <= redirect_target;
            epoch_q  <= ~epoch_q;
          end else begin
            state    <= IDLE;
            flush_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flush_o     = flush_q;
  assign bus.br_target_o = target_q;
  assign bus.epoch_o     = epoch_q;
  assign bus.kill_s1_o   = s0_mis;
  assign bus.br_cnt_o    = br_cnt_q;
  assign bus.mis_cnt_o   = mis_cnt_q;
  assign dbg_state       = (state == REDIR);

endmodule

// File: tb/tb_bpu_update_gen.sv
// tb_bpu_update_gen
//   Directed bench for bpu_update_gen. Expected values are hand-computed per
//   vector; expected redirect targets are also queued and matched against
//   every observed flush pulse.
module tb_bpu_update_gen;

  logic clk;
  logic rst_n;
  logic dbg_state;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  bpu_update_gen_if #(.CNT_W(32)) bus ();

  bpu_update_gen #(.RESET_TARGET(30'h0700_0000), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset ------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking -----------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge. Any flush pulse
  // must match the next queued expected target.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.flush_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_flush", 32'(bus.br_target_o), 32'hFFFF_FFFF);
      else                   check("flush_target_q", 32'(bus.br_target_o), exp_q.pop_front());
    end
  endtask

  // Drivers ------------------------------------------------------------------
  task automatic clear_inputs();
    bus.stall_i       = 1'b0;
    bus.s0_valid_i    = 1'b0;
    bus.s0_epoch_i    = 1'b0;
    bus.s0_pc_i       = '0;
    bus.s0_pred_npc_i = '0;
    bus.s0_taken_i    = 1'b0;
    bus.s0_target_i   = '0;
    bus.s1_valid_i    = 1'b0;
    bus.s1_epoch_i    = 1'b0;
    bus.s1_pc_i       = '0;
    bus.s1_pred_npc_i = '0;
    bus.s1_taken_i    = 1'b0;
    bus.s1_target_i   = '0;
    bus.excp_valid_i  = 1'b0;
    bus.excp_target_i = '0;
  endtask

  task automatic drive_s0(input logic ep, input logic [29:0] pc, input logic [29:0] pred,
                          input logic tk, input logic [29:0] tgt);
    bus.s0_valid_i    = 1'b1;
    bus.s0_epoch_i    = ep;
    bus.s0_pc_i       = pc;
    bus.s0_pred_npc_i = pred;
    bus.s0_taken_i    = tk;
    bus.s0_target_i   = tgt;
  endtask

  task automatic drive_s1(input logic ep, input logic [29:0] pc, input logic [29:0] pred,
                          input logic tk, input logic [29:0] tgt);
    bus.s1_valid_i    = 1'b1;
    bus.s1_epoch_i    = ep;
    bus.s1_pc_i       = pc;
    bus.s1_pred_npc_i = pred;
    bus.s1_taken_i    = tk;
    bus.s1_target_i   = tgt;
  endtask

  task automatic check_state(input string tag, input logic fl, input logic [29:0] tgt,
                             input logic ep, input logic [31:0] brc, input logic [31:0] misc);
    check({tag, "_flush"},  32'(bus.flush_o),     32'(fl));
    check({tag, "_target"}, 32'(bus.br_target_o), 32'(tgt));
    check({tag, "_epoch"},  32'(bus.epoch_o),     32'(ep));
    check({tag, "_br_cnt"}, bus.br_cnt_o,         brc);
    check({tag, "_mis_cnt"}, bus.mis_cnt_o,       misc);
  endtask

  // Directed sequence ----------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 1'b0, 30'h0700_0000, 1'b0, 32'd0, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Correctly predicted not-taken branch.
    drive_s0(1'b0, 30'h100, 30'h101, 1'b0, 30'h0);
    #1 check("t2_kill", 32'(bus.kill_s1_o), 32'd0);
    tick();
    clear_inputs();
    check_state("t2", 1'b0, 30'h0700_0000, 1'b0, 32'd1, 32'd0);

    // Slot0 mispredict with slot1 also mispredicted: slot1 killed.
    drive_s0(1'b0, 30'h100, 30'h101, 1'b1, 30'h200);
    drive_s1(1'b0, 30'h200, 30'h999, 1'b0, 30'h0);
    #1 check("t3_kill", 32'(bus.kill_s1_o), 32'd1);
    exp_q.push_back(32'h200);
    tick();
    clear_inputs();
    check_state("t3", 1'b1, 30'h200, 1'b1, 32'd2, 32'd1);
    check("t3_state", 32'(dbg_state), 32'd1);

    // Old-epoch mispredict during the flush cycle is dropped.
    drive_s0(1'b0, 30'h500, 30'h123, 1'b1, 30'h600);
    #1 check("t4_kill", 32'(bus.kill_s1_o), 32'd0);
    tick();
    clear_inputs();
    check_state("t4", 1'b0, 30'h200, 1'b1, 32'd2, 32'd1);
    check("t4_state", 32'(dbg_state), 32'd0);

    // Exception while stalled with a slot0 mispredict present.
    bus.stall_i       = 1'b1;
    bus.excp_valid_i  = 1'b1;
    bus.excp_target_i = 30'h300;
    drive_s0(1'b1, 30'h700, 30'h111, 1'b0, 30'h0);
    #1 check("t5_kill", 32'(bus.kill_s1_o), 32'd0);
    exp_q.push_back(32'h300);
    tick();
    clear_inputs();
    check_state("t5", 1'b1, 30'h300, 1'b0, 32'd2, 32'd1);
    tick();
    check_state("t5_hold", 1'b0, 30'h300, 1'b0, 32'd2, 32'd1);

    // Wrap of pc+1 at the top of the address space.
    drive_s0(1'b0, 30'h3FFF_FFFF, 30'h0, 1'b0, 30'h0);
    tick();
    clear_inputs();
    check_state("t6_wrap", 1'b0, 30'h300, 1'b0, 32'd3, 32'd1);

    // Stalled mispredict is not accepted.
    bus.stall_i = 1'b1;
    drive_s0(1'b0, 30'h40, 30'h99, 1'b1, 30'h80);
    #1 check("t6_stall_kill", 32'(bus.kill_s1_o), 32'd0);
    tick();
    clear_inputs();
    check_state("t6_stall", 1'b0, 30'h300, 1'b0, 32'd3, 32'd1);

    // Slot1-only mispredict: slot0 correct, slot1 taken to 0x50.
    drive_s0(1'b0, 30'h10, 30'h11, 1'b0, 30'h0);
    drive_s1(1'b0, 30'h11, 30'h12, 1'b1, 30'h50);
    #1 check("t7_kill", 32'(bus.kill_s1_o), 32'd0);
    exp_q.push_back(32'h50);
    tick();
    clear_inputs();
    check_state("t7", 1'b1, 30'h50, 1'b1, 32'd5, 32'd2);

    // New-epoch mispredict while in REDIR: flush again, target 0x61.
    drive_s0(1'b1, 30'h60, 30'h70, 1'b0, 30'h0);
    exp_q.push_back(32'h61);
    tick();
    clear_inputs();
    check_state("t8", 1'b1, 30'h61, 1'b0, 32'd6, 32'd3);
    check("t8_state", 32'(dbg_state), 32'd1);

    // Exception and accepted mispredict together: exception wins, one toggle,
    // mispredict not counted.
    bus.excp_valid_i  = 1'b1;
    bus.excp_target_i = 30'h400;
    drive_s0(1'b0, 30'h80, 30'h90, 1'b0, 30'h0);
    exp_q.push_back(32'h400);
    tick();
    clear_inputs();
    check_state("t9", 1'b1, 30'h400, 1'b1, 32'd7, 32'd3);

    // Asynchronous reset during the flush pulse.
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 30'h0700_0000, 1'b0, 32'd0, 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
